// File: rtl/lc4_pipe_pkg.sv
// Shared constants and entry layout for the LC4 elastic pipeline stage.
// Widths here are the defaults; instantiators may override them.
package lc4_pipe_pkg;

    localparam logic [15:0] LC4_NOP_INSN = 16'h0000;

    localparam int LC4_ROB_IDX_W = 2;
    localparam int LC4_PRD_W     = 4;
    localparam int LC4_PAYLOAD_W = 96;

    typedef struct packed {
        logic                     live;
        logic [15:0]              insn;
        logic [15:0]              pc;
        logic [LC4_ROB_IDX_W-1:0] rob_index;
        logic [LC4_PRD_W-1:0]     prd;
        logic [LC4_PAYLOAD_W-1:0] payload;
    } lc4_entry_t;

    // Number of pointer bits for a power-of-two ring of the given depth.
    function automatic int lc4_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/lc4_elastic_pipe_stage_if.sv
// Producer/consumer handshake bundle around the elastic stage.
// master = environment side, slave = the stage itself.
interface lc4_elastic_pipe_stage_if #(
    parameter int PAYLOAD_W = 96,
    parameter int ROB_IDX_W = 2,
    parameter int PRD_W     = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [15:0]          in_insn;
    logic [15:0]          in_pc;
    logic [ROB_IDX_W-1:0] in_rob_index;
    logic [PRD_W-1:0]     in_prd;
    logic [PAYLOAD_W-1:0] in_payload;

    logic                 out_valid;
    logic                 out_ready;
    logic [15:0]          out_insn;
    logic [15:0]          out_pc;
    logic [ROB_IDX_W-1:0] out_rob_index;
    logic [PRD_W-1:0]     out_prd;
    logic [PAYLOAD_W-1:0] out_payload;

    modport master (
        output in_valid, in_insn, in_pc, in_rob_index, in_prd, in_payload,
        output out_ready,
        input  in_ready,
        input  out_valid, out_insn, out_pc, out_rob_index, out_prd,
        input  out_payload
    );

    modport slave (
        input  in_valid, in_insn, in_pc, in_rob_index, in_prd, in_payload,
        input  out_ready,
        output in_ready,
        output out_valid, out_insn, out_pc, out_rob_index, out_prd,
        output out_payload
    );

endinterface

// File: rtl/lc4_pipe_slot.sv
// One ring-buffer entry: live bit, ROB index and opaque field bundle.
// Clear beats load, load beats kill (a loaded slot was empty before).
module lc4_pipe_slot #(
    parameter int ROB_IDX_W = 2,
    parameter int DATA_W    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_en,
    input  logic                    i_clear,
    input  logic                    i_load,
    input  logic [2**ROB_IDX_W-1:0] i_kill_mask,
    input  logic [ROB_IDX_W-1:0]    i_rob,
    input  logic [DATA_W-1:0]       i_data,
    output logic                    o_live,
    output logic [ROB_IDX_W-1:0]    o_rob,
    output logic [DATA_W-1:0]       o_data
);

    logic                 r_live;
    logic [ROB_IDX_W-1:0] r_rob;
    logic [DATA_W-1:0]    r_data;
    logic                 w_killed;

    assign w_killed = i_kill_mask[r_rob];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_live <= 1'b0;
            r_rob  <= '0;
            r_data <= '0;
        end else if (i_en) begin
            if (i_clear) begin
                r_live <= 1'b0;
            end else if (i_load) begin
                r_live <= 1'b1;
                r_rob  <= i_rob;
                r_data <= i_data;
            end else if (w_killed) begin
                r_live <= 1'b0;
            end
        end
    end

    assign o_live = r_live;
    assign o_rob  = r_rob;
    assign o_data = r_data;

endmodule

// File: rtl/lc4_elastic_pipe_stage.sv
// Elastic N-entry pipeline stage with valid/ready handshake,
// full flush and ROB-indexed squash; killed slots drain as bubbles.
module lc4_elastic_pipe_stage
    import lc4_pipe_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int PAYLOAD_W = LC4_PAYLOAD_W,
    parameter int ROB_IDX_W = LC4_ROB_IDX_W,
    parameter int PRD_W     = LC4_PRD_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       gwe,
    input  logic                       flush,
    input  logic [2**ROB_IDX_W-1:0]    kill_mask,
    lc4_elastic_pipe_stage_if.slave    io,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = lc4_ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [15:0]          insn;
        logic [15:0]          pc;
        logic [PRD_W-1:0]     prd;
        logic [PAYLOAD_W-1:0] payload;
    } data_t;

    localparam int DW = $bits(data_t);

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic                 w_live [DEPTH];
    logic [ROB_IDX_W-1:0] w_rob  [DEPTH];
    data_t                w_data [DEPTH];
    data_t                w_in_data;

    logic w_in_ready;
    logic w_push;
    logic w_hd_occ;
    logic w_hd_live;
    logic w_hd_killed;
    logic w_out_valid;
    logic w_pop;
    logic w_drain;
    logic w_adv;

    assign w_in_data = '{
        insn:    io.in_insn,
        pc:      io.in_pc,
        prd:     io.in_prd,
        payload: io.in_payload
    };

    // in_ready depends on registered occupancy only, never on out_ready.
    assign w_in_ready = (r_count < FULL);
    assign w_push     = io.in_valid & w_in_ready & ~flush
                      & ~kill_mask[io.in_rob_index];

    assign w_hd_occ    = (r_count != '0);
    assign w_hd_live   = w_live[r_head];
    assign w_hd_killed = kill_mask[w_rob[r_head]];
    assign w_out_valid = w_hd_occ & w_hd_live;

    // A head squashed this cycle is not popped; it drains next cycle.
    assign w_pop   = w_out_valid & io.out_ready & ~w_hd_killed;
    assign w_drain = w_hd_occ & ~w_hd_live;
    assign w_adv   = w_pop | w_drain;

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        logic w_load;
        logic [DW-1:0] w_q;

        assign w_load    = w_push & (r_tail == PW'(g));
        assign w_data[g] = data_t'(w_q);

        lc4_pipe_slot #(
            .ROB_IDX_W (ROB_IDX_W),
            .DATA_W    (DW)
        ) u_slot (
            .clk         (clk),
            .rst         (rst),
            .i_en        (gwe),
            .i_clear     (flush),
            .i_load      (w_load),
            .i_kill_mask (kill_mask),
            .i_rob       (io.in_rob_index),
            .i_data      (w_in_data),
            .o_live      (w_live[g]),
            .o_rob       (w_rob[g]),
            .o_data      (w_q)
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (gwe) begin
            if (flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_adv)
                    r_head <= r_head + PW'(1);
                if (w_push)
                    r_tail <= r_tail + PW'(1);
                unique case ({w_push, w_adv})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Invalid head presents a NOP with every field zeroed.
    always_comb begin
        io.out_insn      = LC4_NOP_INSN;
        io.out_pc        = '0;
        io.out_rob_index = '0;
        io.out_prd       = '0;
        io.out_payload   = '0;
        if (w_out_valid) begin
            io.out_insn      = w_data[r_head].insn;
            io.out_pc        = w_data[r_head].pc;
            io.out_rob_index = w_rob[r_head];
            io.out_prd       = w_data[r_head].prd;
            io.out_payload   = w_data[r_head].payload;
        end
    end

    assign io.out_valid = w_out_valid;
    assign io.in_ready  = w_in_ready;
    assign count        = r_count;

endmodule
